control_sequencer: RTL
======================

# control_sequencer

Multi-cycle control unit for the Mini SRC datapath. It runs the fetch cycles (T0–T2) and, for register-to-register ALU, MUL/DIV, NOP and HALT instructions, the execute cycles (T3–T6). It drives every bus-select, register-enable, memory and ALU-operation strobe of the datapath. It sits beside the datapath, reads the IR contents back, and handshakes with memory during the instruction read.

## Interface
- Parameters: none.
- Clock  in  1  rising-edge clock shared with the datapath
- Clear  in  1  synchronous, active-high reset
- Run  in  1  start/continue; sampled in IDLE and at end of each instruction
- MemRdy  in  1  memory read data valid on Mdatain (T1 handshake)
- IR  in  32  IR register contents; opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15]
- PCout, Zlowout, Zhighout, MDRout, LOout, HIout  out  1 each  bus source selects
- Rout  out  16  one-hot general-register bus select, bit n = Rn
- Rin  out  16  general-register write enables, bit n = Rn; bit 0 is always 0
- PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin  out  1 each  register enables
- Read, IncPC  out  1 each  MDR memory select / PC+1 ALU override
- AluOp  out  13  one-hot: [0]ADD [1]SUB [2]MUL [3]DIV [4]SHR [5]SHRA [6]SHL [7]ROR [8]ROL [9]AND [10]OR [11]NEG [12]NOT
- Halted  out  1  high while in HALT
- Illegal  out  1  one-cycle pulse on an undefined opcode

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. One binary state register. All outputs are combinational decodes of state, IR, and MemRdy (T1 only).
- IDLE: all outputs 0. If Run=1, go to T0.
- T0: PCout, MARin, IncPC, Zin. Go to T1.
- T1: Read=1. While MemRdy=0, stay in T1 with everything else 0. When MemRdy=1, also assert Zlowout, PCin, MDRin and go to T2.
- T2: MDRout, IRin. Go to T3.
- Opcodes: add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011, mul 01111, div 10000, neg 10001, not 10010, nop 11010, halt 11011. Any other opcode is illegal.
- T3 (decode):
  - ALU op: Rout[Rb], Yin; go to T4.
  - nop: no strobes; go to end-of-instruction.
  - halt: no strobes; go to HALT.
  - illegal: Illegal=1, no other strobes; go to end-of-instruction.
- T4:
  - Binary ops: Rout[Rc], matching AluOp bit, Zin.
  - neg/not: Rout[Rb], AluOp bit, Zin; Rc is ignored.
  - Go to T5.
- T5:
  - mul/div: Zlowout, LOin; go to T6.
  - Otherwise: Zlowout, Rin[Ra] (suppressed when Ra=0); go to end-of-instruction.
- T6 (mul/div only): Zhighout, HIin; go to end-of-instruction.
- End-of-instruction: go to T0 if Run=1, else IDLE.
- HALT: Halted=1, all other outputs 0. Only Clear exits.
- At most one bus source (PCout, Zlowout, Zhighout, MDRout, LOout, HIout, Rout bits) is high in any cycle.

## Timing
- Clear=1 at a rising edge → state IDLE, every output 0 from the next cycle. This holds from any state, including mid-instruction or mid-stall. Clear overrides Run.
- Latency from T0 entry, with MemRdy high in T1:
  - ALU op: 6 cycles
  - mul/div: 7 cycles
  - nop/illegal: 4 cycles
  - halt: Halted high in cycle 5
- Each MemRdy=0 cycle in T1 adds one cycle. PCin and MDRin pulse exactly once per fetch.
- Back-to-back: with Run held high, the next T0 directly follows the last execute cycle. No bubble.
- Run dropping mid-instruction does not abort; it takes effect at end-of-instruction.

## Configuration
- CTRL_RETIRE_COUNT_EN defined:
  - Adds output RetireCount (32 bits), reset to 0 by Clear.
  - Increments by 1 on the final cycle of each completed add..not, mul, div or nop instruction. Halt and illegal opcodes do not count.
  - Wraps 0xFFFFFFFF → 0.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Clear, Run=1, MemRdy=1, IR=0x1A920000 (add R5,R2,R4):
  - T0 PCout/MARin/IncPC/Zin
  - T3 Rout=0x0004, Yin
  - T4 Rout=0x0010, AluOp=0x0001, Zin
  - T5 Zlowout, Rin=0x0020
  - Next cycle T0
- IR=0x78188000 (mul R3,R1): T4 Rout=0x0002, AluOp=0x0004; T5 Zlowout+LOin; T6 Zhighout+HIin; Rin stays 0; 7 cycles total.
- MemRdy low for 3 cycles in T1 → T1 lasts 4 cycles with Read high throughout; PCin/MDRin/Zlowout high only in the 4th.
- IR=0x18100000 (add with Ra=0) → T5 Zlowout=1, Rin=0x0000. IR=0xF8000000 → Illegal=1 for one cycle in T3, no Zin, then T0.
- IR=0xD8000000 (halt) → Halted=1 held for 10 cycles with Run=1. Clear → IDLE with all outputs 0. Clear asserted in T4 of an add → next cycle all outputs 0, no Rin pulse.
- With CTRL_RETIRE_COUNT_EN: 3 adds, 1 mul, 1 illegal, 1 halt → RetireCount=4. Clear → 0.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: Mini SRC multi-cycle control unit (fetch T0-T2, reg-reg execute T3-T6).
// Define CTRL_RETIRE_COUNT_EN to add the o_retire_count retired-instruction counter.
module control_sequencer (
  input  logic        i_clock,
  input  logic        i_clear,
  input  logic        i_run,
  input  logic        i_mem_rdy,
  input  logic [31:0] i_ir,
  output logic        o_pc_out,
  output logic        o_zlow_out,
  output logic        o_zhigh_out,
  output logic        o_mdr_out,
  output logic        o_lo_out,
  output logic        o_hi_out,
  output logic [15:0] o_rout,
  output logic [15:0] o_rin,
  output logic        o_pc_in,
  output logic        o_ir_in,
  output logic        o_mar_in,
  output logic        o_mdr_in,
  output logic        o_y_in,
  output logic        o_z_in,
  output logic        o_lo_in,
  output logic        o_hi_in,
  output logic        o_read,
  output logic        o_inc_pc,
  output logic [12:0] o_alu_op,
  output logic        o_halted,
  output logic        o_illegal
`ifdef CTRL_RETIRE_COUNT_EN
  ,
  output logic [31:0] o_retire_count
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  state_t      r_state;
  logic [4:0]  w_opcode;
  logic [3:0]  w_ra, w_rb, w_rc;
  logic [15:0] w_ra_sel, w_rb_sel, w_rc_sel;
  logic [12:0] w_alu;
  logic        w_is_alu, w_is_muldiv, w_is_unary, w_is_nop, w_is_halt;
  logic        w_unused_ir;
  state_t      w_eoi_state;

  assign w_opcode    = i_ir[31:27];
  assign w_ra        = i_ir[26:23];
  assign w_rb        = i_ir[22:19];
  assign w_rc        = i_ir[18:15];
  assign w_unused_ir = ^i_ir[14:0];
  assign w_rb_sel    = 16'd1 << w_rb;
  assign w_rc_sel    = 16'd1 << w_rc;
  // R0 is never a write target
  assign w_ra_sel    = (w_ra == 4'd0) ? 16'd0 : (16'd1 << w_ra);
  assign w_eoi_state = i_run ? S_T0 : S_IDLE;

  always_comb begin
    w_alu = '0;
    case (w_opcode)
      5'b00011: w_alu[0]  = 1'b1;
      5'b00100: w_alu[1]  = 1'b1;
      5'b01111: w_alu[2]  = 1'b1;
      5'b10000: w_alu[3]  = 1'b1;
      5'b01001: w_alu[4]  = 1'b1;
      5'b01010: w_alu[5]  = 1'b1;
      5'b01011: w_alu[6]  = 1'b1;
      5'b00111: w_alu[7]  = 1'b1;
      5'b01000: w_alu[8]  = 1'b1;
      5'b00101: w_alu[9]  = 1'b1;
      5'b00110: w_alu[10] = 1'b1;
      5'b10001: w_alu[11] = 1'b1;
      5'b10010: w_alu[12] = 1'b1;
      default:  w_alu = '0;
    endcase
    w_is_alu    = |w_alu;
    w_is_muldiv = w_alu[2] | w_alu[3];
    w_is_unary  = w_alu[11] | w_alu[12];
    w_is_nop    = (w_opcode == 5'b11010);
    w_is_halt   = (w_opcode == 5'b11011);
  end

  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (i_run) r_state <= S_T0;
        S_T0:   r_state <= S_T1;
        S_T1:   if (i_mem_rdy) r_state <= S_T2;
        S_T2:   r_state <= S_T3;
        S_T3: begin
          if (w_is_alu)       r_state <= S_T4;
          else if (w_is_halt) r_state <= S_HALT;
          else                r_state <= w_eoi_state;
        end
        S_T4:   r_state <= S_T5;
        S_T5:   r_state <= w_is_muldiv ? S_T6 : w_eoi_state;
        S_T6:   r_state <= w_eoi_state;
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_pc_out = 1'b0; o_zlow_out = 1'b0; o_zhigh_out = 1'b0; o_mdr_out = 1'b0;
    o_lo_out = 1'b0; o_hi_out = 1'b0; o_rout = '0; o_rin = '0;
    o_pc_in = 1'b0; o_ir_in = 1'b0; o_mar_in = 1'b0; o_mdr_in = 1'b0;
    o_y_in = 1'b0; o_z_in = 1'b0; o_lo_in = 1'b0; o_hi_in = 1'b0;
    o_read = 1'b0; o_inc_pc = 1'b0; o_alu_op = '0; o_halted = 1'b0; o_illegal = 1'b0;
    case (r_state)
      S_T0: begin
        o_pc_out = 1'b1; o_mar_in = 1'b1; o_inc_pc = 1'b1; o_z_in = 1'b1;
      end
      S_T1: begin
        o_read = 1'b1;
        if (i_mem_rdy) begin
          o_zlow_out = 1'b1; o_pc_in = 1'b1; o_mdr_in = 1'b1;
        end
      end
      S_T2: begin
        o_mdr_out = 1'b1; o_ir_in = 1'b1;
      end
      S_T3: begin
        if (w_is_alu) begin
          o_rout = w_rb_sel; o_y_in = 1'b1;
        end else if (!w_is_nop && !w_is_halt) begin
          o_illegal = 1'b1;
        end
      end
      S_T4: begin
        o_rout   = w_is_unary ? w_rb_sel : w_rc_sel;
        o_alu_op = w_alu;
        o_z_in   = 1'b1;
      end
      S_T5: begin
        o_zlow_out = 1'b1;
        if (w_is_muldiv) o_lo_in = 1'b1;
        else             o_rin   = w_ra_sel;
      end
      S_T6: begin
        o_zhigh_out = 1'b1; o_hi_in = 1'b1;
      end
      S_HALT: o_halted = 1'b1;
      default: ;
    endcase
  end

`ifdef CTRL_RETIRE_COUNT_EN
  logic        w_retire;
  logic [31:0] r_retire_count;

  // final cycle of a completed nop, single-cycle-result ALU op, or mul/div
  assign w_retire = ((r_state == S_T3) && w_is_nop) ||
                    ((r_state == S_T5) && w_is_alu && !w_is_muldiv) ||
                    (r_state == S_T6);

  always_ff @(posedge i_clock) begin
    if (i_clear)       r_retire_count <= '0;
    else if (w_retire) r_retire_count <= r_retire_count + 32'd1;
  end

  assign o_retire_count = r_retire_count;
`endif

endmodule
